// File: rtl/csr_file_v2.sv
// ---------------------------------------------------------------------------
// csr_file_v2
// Machine-mode CSR file for a single-hart core. It holds the trap CSRs,
// the two free-running counters and the interrupt pending/enable state. It
// also resolves trap, interrupt and mret events into a one-cycle redirect.
//
// Ports
//   clk, rst            sole clock, asynchronous active-high reset
//   i_csr_op            00 none, 01 RW, 10 RS, 11 RC
//   i_csr_addr          CSR address
//   i_csr_wdata         write operand
//   o_csr_rdata         pre-write CSR value, 0 when idle or illegal
//   o_csr_illegal       access is illegal
//   i_instr_retire      one instruction retired this cycle
//   i_ecall/i_ebreak    exception events
//   i_mret              return-from-trap event
//   i_trap_pc           PC saved into mepc on a trap
//   i_irq_timer/soft/ext  level interrupt lines
//   o_intr_pending      an enabled interrupt can be taken
//   i_intr_take         core takes the pending interrupt this cycle
//   o_redirect_valid    one-cycle redirect strobe
//   o_redirect_pc       redirect target
// ---------------------------------------------------------------------------
module csr_file_v2 #(
  parameter int          XLEN        = 64,
  parameter logic [63:0] MSTATUS_RST = 64'ha00001800,
  parameter logic [63:0] HARTID      = 64'd0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      i_csr_op,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wdata,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_csr_illegal,
  input  logic            i_instr_retire,
  input  logic            i_ecall,
  input  logic            i_ebreak,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic            i_irq_timer,
  input  logic            i_irq_soft,
  input  logic            i_irq_ext,
  output logic            o_intr_pending,
  input  logic            i_intr_take,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc
);

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csrOp_e;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [XLEN-1:0] MSTATUS_INIT = MSTATUS_RST[XLEN-1:0];
  localparam logic [XLEN-1:0] HARTID_VAL   = HARTID[XLEN-1:0];
  localparam logic [XLEN-1:0] IRQ_MASK     = XLEN'(12'h888);
  localparam logic [XLEN-1:0] ALIGN_MASK   = ~XLEN'(3);

  // mstatus field positions
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mip_q, mip_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;
  logic            redirectValid_q, redirectValid_d;
  logic [XLEN-1:0] redirectPc_q, redirectPc_d;

  csrOp_e          csrOp;
  logic            csrHit;
  logic [XLEN-1:0] csrValue;
  logic [XLEN-1:0] writeValue;
  logic            writeAttempt;
  logic            csrIllegal;
  logic [XLEN-1:0] enabledIrq;
  logic [3:0]      intrCause;
  logic            intrTake;
  logic            trapEvent;
  logic            mretEvent;
  logic            csrWrite;
  logic [XLEN-1:0] trapCause;
  logic [XLEN-1:0] mtvecBase;
  logic [XLEN-1:0] trapTarget;

  assign csrOp = csrOp_e'(i_csr_op);

  // Address decode: select the current value of the addressed CSR and flag
  // whether the address names an implemented register at all.
  always_comb begin
    csrHit   = 1'b1;
    csrValue = '0;
    case (i_csr_addr)
      ADDR_MSTATUS:  csrValue = mstatus_q;
      ADDR_MIE:      csrValue = mie_q;
      ADDR_MTVEC:    csrValue = mtvec_q;
      ADDR_MSCRATCH: csrValue = mscratch_q;
      ADDR_MEPC:     csrValue = mepc_q;
      ADDR_MCAUSE:   csrValue = mcause_q;
      ADDR_MTVAL:    csrValue = mtval_q;
      ADDR_MIP:      csrValue = mip_q;
      ADDR_MCYCLE:   csrValue = mcycle_q;
      ADDR_MINSTRET: csrValue = minstret_q;
      ADDR_MHARTID:  csrValue = HARTID_VAL;
      default:       csrHit   = 1'b0;
    endcase
  end

  // Set/clear with a zero operand is a pure read, so it may target the
  // read-only space without faulting.
  assign writeAttempt = (csrOp == OP_RW) ||
                        ((csrOp == OP_RS || csrOp == OP_RC) && (|i_csr_wdata));
  assign csrIllegal   = (csrOp != OP_NONE) &&
                        (!csrHit || (writeAttempt && i_csr_addr[11:10] == 2'b11));

  assign o_csr_illegal = csrIllegal;
  assign o_csr_rdata   = (csrOp == OP_NONE || csrIllegal) ? '0 : csrValue;

  // Read-modify-write operand for the three CSR instructions.
  always_comb begin
    writeValue = csrValue;
    case (csrOp)
      OP_RW:   writeValue = i_csr_wdata;
      OP_RS:   writeValue = csrValue | i_csr_wdata;
      OP_RC:   writeValue = csrValue & ~i_csr_wdata;
      default: writeValue = csrValue;
    endcase
  end

  // Interrupt arbitration: external beats software beats timer.
  assign enabledIrq     = mip_q & mie_q & IRQ_MASK;
  assign o_intr_pending = mstatus_q[MIE_BIT] && (|enabledIrq);

  always_comb begin
    intrCause = 4'd7;
    if (enabledIrq[11]) begin
      intrCause = 4'd11;
    end else if (enabledIrq[3]) begin
      intrCause = 4'd3;
    end
  end

  // Only one event wins per cycle; a take with nothing pending is dropped.
  assign intrTake  = i_intr_take && o_intr_pending;
  assign trapEvent = intrTake || i_ebreak || i_ecall;
  assign mretEvent = i_mret && !trapEvent;
  assign csrWrite  = writeAttempt && !csrIllegal && !trapEvent && !i_mret;

  // Cause code and handler address for whichever trap is being taken.
  always_comb begin
    if (intrTake) begin
      trapCause = {1'b1, {(XLEN-5){1'b0}}, intrCause};
    end else if (i_ebreak) begin
      trapCause = XLEN'(3);
    end else begin
      trapCause = XLEN'(11);
    end
  end

  assign mtvecBase  = mtvec_q & ALIGN_MASK;
  assign trapTarget = (intrTake && mtvec_q[1:0] == 2'b01) ?
                      mtvecBase + (XLEN'(intrCause) << 2) : mtvecBase;

  // Next-state for every register. Counters advance unless a CSR write to
  // that counter lands in the same cycle.
  always_comb begin
    mstatus_d       = mstatus_q;
    mie_d           = mie_q;
    mtvec_d         = mtvec_q;
    mscratch_d      = mscratch_q;
    mepc_d          = mepc_q;
    mcause_d        = mcause_q;
    mtval_d         = mtval_q;
    mip_d           = '0;
    mip_d[3]        = i_irq_soft;
    mip_d[7]        = i_irq_timer;
    mip_d[11]       = i_irq_ext;
    mcycle_d        = mcycle_q + XLEN'(1);
    minstret_d      = minstret_q + XLEN'(i_instr_retire);
    redirectValid_d = 1'b0;
    redirectPc_d    = redirectPc_q;

    if (trapEvent) begin
      mepc_d                 = i_trap_pc & ALIGN_MASK;
      mcause_d               = trapCause;
      mtval_d                = '0;
      mstatus_d[MPIE_BIT]    = mstatus_q[MIE_BIT];
      mstatus_d[MIE_BIT]     = 1'b0;
      mstatus_d[12:11]       = 2'b11;
      redirectValid_d        = 1'b1;
      redirectPc_d           = trapTarget;
    end else if (mretEvent) begin
      mstatus_d[MIE_BIT]     = mstatus_q[MPIE_BIT];
      mstatus_d[MPIE_BIT]    = 1'b1;
      mstatus_d[12:11]       = 2'b11;
      redirectValid_d        = 1'b1;
      redirectPc_d           = mepc_q;
    end else if (csrWrite) begin
      case (i_csr_addr)
        ADDR_MSTATUS:  mstatus_d  = writeValue;
        ADDR_MIE:      mie_d      = writeValue;
        ADDR_MTVEC:    mtvec_d    = writeValue;
        ADDR_MSCRATCH: mscratch_d = writeValue;
        ADDR_MEPC:     mepc_d     = writeValue & ALIGN_MASK;
        ADDR_MCAUSE:   mcause_d   = writeValue;
        ADDR_MTVAL:    mtval_d    = writeValue;
        ADDR_MCYCLE:   mcycle_d   = writeValue;
        ADDR_MINSTRET: minstret_d = writeValue;
        default:       mtval_d    = mtval_q;
      endcase
    end
  end

  // State registers; reset also cancels any redirect in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q       <= MSTATUS_INIT;
      mie_q           <= '0;
      mtvec_q         <= '0;
      mscratch_q      <= '0;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mtval_q         <= '0;
      mip_q           <= '0;
      mcycle_q        <= '0;
      minstret_q      <= '0;
      redirectValid_q <= 1'b0;
      redirectPc_q    <= '0;
    end else begin
      mstatus_q       <= mstatus_d;
      mie_q           <= mie_d;
      mtvec_q         <= mtvec_d;
      mscratch_q      <= mscratch_d;
      mepc_q          <= mepc_d;
      mcause_q        <= mcause_d;
      mtval_q         <= mtval_d;
      mip_q           <= mip_d;
      mcycle_q        <= mcycle_d;
      minstret_q      <= minstret_d;
      redirectValid_q <= redirectValid_d;
      redirectPc_q    <= redirectPc_d;
    end
  end

  assign o_redirect_valid = redirectValid_q;
  assign o_redirect_pc    = redirectPc_q;

endmodule

// File: tb/tb_csr_file_v2.sv
// ---------------------------------------------------------------------------
// tb_csr_file_v2
// Self-checking bench for csr_file_v2. A reference model keeps the CSRs in
// an associative array keyed by address and applies the architectural
// trap/mret/write rules once per clock. Directed scenarios are followed by
// a randomized phase; every output is compared against the model.
// ---------------------------------------------------------------------------
module tb_csr_file_v2;

  localparam int          XLEN        = 64;
  localparam logic [63:0] MSTATUS_RST = 64'ha00001800;
  localparam logic [63:0] HARTID      = 64'd5;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  // event flag bits for applyStimulus
  localparam logic [7:0] EV_ECALL  = 8'h01;
  localparam logic [7:0] EV_EBREAK = 8'h02;
  localparam logic [7:0] EV_MRET   = 8'h04;
  localparam logic [7:0] EV_RETIRE = 8'h08;
  localparam logic [7:0] EV_IRQT   = 8'h10;
  localparam logic [7:0] EV_IRQS   = 8'h20;
  localparam logic [7:0] EV_IRQE   = 8'h40;
  localparam logic [7:0] EV_TAKE   = 8'h80;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      i_csr_op;
  logic [11:0]     i_csr_addr;
  logic [XLEN-1:0] i_csr_wdata;
  logic [XLEN-1:0] o_csr_rdata;
  logic            o_csr_illegal;
  logic            i_instr_retire;
  logic            i_ecall;
  logic            i_ebreak;
  logic            i_mret;
  logic [XLEN-1:0] i_trap_pc;
  logic            i_irq_timer;
  logic            i_irq_soft;
  logic            i_irq_ext;
  logic            o_intr_pending;
  logic            i_intr_take;
  logic            o_redirect_valid;
  logic [XLEN-1:0] o_redirect_pc;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [63:0] csr [logic [11:0]];
  logic        modelRedirValid;
  logic [63:0] modelRedirPc;

  csr_file_v2 #(
    .XLEN(XLEN),
    .MSTATUS_RST(MSTATUS_RST),
    .HARTID(HARTID)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_csr_op(i_csr_op),
    .i_csr_addr(i_csr_addr),
    .i_csr_wdata(i_csr_wdata),
    .o_csr_rdata(o_csr_rdata),
    .o_csr_illegal(o_csr_illegal),
    .i_instr_retire(i_instr_retire),
    .i_ecall(i_ecall),
    .i_ebreak(i_ebreak),
    .i_mret(i_mret),
    .i_trap_pc(i_trap_pc),
    .i_irq_timer(i_irq_timer),
    .i_irq_soft(i_irq_soft),
    .i_irq_ext(i_irq_ext),
    .o_intr_pending(o_intr_pending),
    .i_intr_take(i_intr_take),
    .o_redirect_valid(o_redirect_valid),
    .o_redirect_pc(o_redirect_pc)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void modelReset();
    csr.delete();
    csr[12'h300] = MSTATUS_RST;
    csr[12'h304] = 64'd0;
    csr[12'h305] = 64'd0;
    csr[12'h340] = 64'd0;
    csr[12'h341] = 64'd0;
    csr[12'h342] = 64'd0;
    csr[12'h343] = 64'd0;
    csr[12'h344] = 64'd0;
    csr[12'hB00] = 64'd0;
    csr[12'hB02] = 64'd0;
    csr[12'hF14] = HARTID;
    modelRedirValid = 1'b0;
    modelRedirPc    = 64'd0;
  endfunction

  function automatic bit modelAttempt();
    return (i_csr_op == OP_RW) || (i_csr_op != OP_NONE && i_csr_wdata != 64'd0);
  endfunction

  function automatic bit modelIllegal();
    logic [11:0] a = i_csr_addr;
    if (i_csr_op == OP_NONE) return 1'b0;
    if (!csr.exists(a)) return 1'b1;
    return modelAttempt() && (a[11:10] == 2'b11);
  endfunction

  function automatic logic [63:0] modelRdata();
    if (i_csr_op == OP_NONE || modelIllegal()) return 64'd0;
    return csr[i_csr_addr];
  endfunction

  function automatic logic [63:0] modelActiveIrqs();
    return csr[12'h344] & csr[12'h304] & 64'h888;
  endfunction

  function automatic bit modelPending();
    logic [63:0] st = csr[12'h300];
    return st[3] && (modelActiveIrqs() != 64'd0);
  endfunction

  // One clock edge of architectural behaviour.
  function automatic void modelStep();
    logic [63:0] st        = csr[12'h300];
    logic [63:0] oldCycle  = csr[12'hB00];
    logic [63:0] oldInst   = csr[12'hB02];
    logic [63:0] tvec      = csr[12'h305];
    logic [63:0] active    = modelActiveIrqs();
    bit          takeIrq   = i_intr_take && modelPending();
    bit          cycleWr   = 1'b0;
    bit          instWr    = 1'b0;
    logic [63:0] oldVal;
    logic [63:0] newVal;
    logic [63:0] cause;
    modelRedirValid = 1'b0;
    if (takeIrq || i_ebreak || i_ecall) begin
      if (takeIrq) begin
        cause = active[11] ? 64'd11 : (active[3] ? 64'd3 : 64'd7);
        csr[12'h342] = (64'd1 << 63) | cause;
        modelRedirPc = (tvec[1:0] == 2'b01) ? (tvec & ~64'd3) + 4 * cause : (tvec & ~64'd3);
      end else begin
        csr[12'h342] = i_ebreak ? 64'd3 : 64'd11;
        modelRedirPc = tvec & ~64'd3;
      end
      csr[12'h341] = i_trap_pc & ~64'd3;
      csr[12'h343] = 64'd0;
      st[7] = st[3];
      st[3] = 1'b0;
      st[12:11] = 2'b11;
      csr[12'h300] = st;
      modelRedirValid = 1'b1;
    end else if (i_mret) begin
      modelRedirPc = csr[12'h341];
      st[3] = st[7];
      st[7] = 1'b1;
      st[12:11] = 2'b11;
      csr[12'h300] = st;
      modelRedirValid = 1'b1;
    end else if (modelAttempt() && !modelIllegal()) begin
      oldVal = csr[i_csr_addr];
      case (i_csr_op)
        OP_RS:   newVal = oldVal | i_csr_wdata;
        OP_RC:   newVal = oldVal & ~i_csr_wdata;
        default: newVal = i_csr_wdata;
      endcase
      if (i_csr_addr == 12'h341) newVal = newVal & ~64'd3;
      if (i_csr_addr != 12'h344) csr[i_csr_addr] = newVal;
      cycleWr = (i_csr_addr == 12'hB00);
      instWr  = (i_csr_addr == 12'hB02);
    end
    if (!cycleWr) csr[12'hB00] = oldCycle + 64'd1;
    if (!instWr && i_instr_retire) csr[12'hB02] = oldInst + 64'd1;
    csr[12'h344] = {52'd0, i_irq_ext, 3'd0, i_irq_timer, 3'd0, i_irq_soft, 3'd0};
  endfunction

  // Drive one cycle of inputs on the falling edge and compare every output
  // against the model once they settle.
  task automatic applyStimulus(input logic [1:0] op, input logic [11:0] addr,
                               input logic [63:0] wd, input logic [7:0] ev,
                               input logic [63:0] pc);
    @(negedge clk);
    i_csr_op       = op;
    i_csr_addr     = addr;
    i_csr_wdata    = wd;
    i_ecall        = ev[0];
    i_ebreak       = ev[1];
    i_mret         = ev[2];
    i_instr_retire = ev[3];
    i_irq_timer    = ev[4];
    i_irq_soft     = ev[5];
    i_irq_ext      = ev[6];
    i_intr_take    = ev[7];
    i_trap_pc      = pc;
    #1;
    checkOutput("rdata", o_csr_rdata, modelRdata());
    checkOutput("illegal", 64'(o_csr_illegal), 64'(modelIllegal()));
    checkOutput("pending", 64'(o_intr_pending), 64'(modelPending()));
    checkOutput("redir_valid", 64'(o_redirect_valid), 64'(modelRedirValid));
    checkOutput("redir_pc", o_redirect_pc, modelRedirPc);
  endtask

  task automatic clockEdge();
    @(posedge clk);
    if (rst) modelReset();
    else modelStep();
  endtask

  logic [11:0] addrs [14] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                              12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02,
                              12'hF14, 12'h7C0, 12'h001, 12'hF11};

  initial begin
    logic [63:0] wd;
    logic [7:0]  ev;
    rst = 1'b1;
    i_csr_op = OP_NONE; i_csr_addr = '0; i_csr_wdata = '0;
    i_instr_retire = 0; i_ecall = 0; i_ebreak = 0; i_mret = 0;
    i_trap_pc = '0; i_irq_timer = 0; i_irq_soft = 0; i_irq_ext = 0;
    i_intr_take = 0;
    modelReset();
    repeat (2) @(posedge clk);

    // reset state, then first count after release
    applyStimulus(OP_RS, 12'h300, 64'd0, 8'h00, 64'd0);
    checkOutput("rst_mstatus", o_csr_rdata, MSTATUS_RST);
    checkOutput("rst_redir_valid", 64'(o_redirect_valid), 64'd0);
    clockEdge();
    #1 rst = 1'b0;
    applyStimulus(OP_RS, 12'hB00, 64'd0, 8'h00, 64'd0);
    checkOutput("mcycle_start", o_csr_rdata, 64'd0);
    clockEdge();
    applyStimulus(OP_RS, 12'hB00, 64'd0, 8'h00, 64'd0);
    checkOutput("mcycle_first", o_csr_rdata, 64'd1);
    clockEdge();

    // csrrw mtvec then ecall
    applyStimulus(OP_RW, 12'h305, 64'h8000_0101, 8'h00, 64'd0);
    clockEdge();
    applyStimulus(OP_NONE, 12'h000, 64'd0, EV_ECALL, 64'h8000_0010);
    clockEdge();
    applyStimulus(OP_RS, 12'h341, 64'd0, 8'h00, 64'd0);
    checkOutput("ecall_redir_valid", 64'(o_redirect_valid), 64'd1);
    checkOutput("ecall_redir_pc", o_redirect_pc, 64'h8000_0100);
    checkOutput("ecall_mepc", o_csr_rdata, 64'h8000_0010);
    clockEdge();
    applyStimulus(OP_RS, 12'h342, 64'd0, 8'h00, 64'd0);
    checkOutput("ecall_mcause", o_csr_rdata, 64'hb);
    checkOutput("redir_one_cycle", 64'(o_redirect_valid), 64'd0);
    clockEdge();
    applyStimulus(OP_RS, 12'h300, 64'd0, 8'h00, 64'd0);
    checkOutput("ecall_mie", 64'(o_csr_rdata[3]), 64'd0);
    clockEdge();

    // vectored interrupt, ext beats timer
    applyStimulus(OP_RS, 12'h300, 64'h8, 8'h00, 64'd0);
    clockEdge();
    applyStimulus(OP_RW, 12'h304, 64'h880, 8'h00, 64'd0);
    clockEdge();
    applyStimulus(OP_RW, 12'h305, 64'h101, 8'h00, 64'd0);
    clockEdge();
    applyStimulus(OP_NONE, 12'h000, 64'd0, EV_IRQT | EV_IRQE, 64'd0);
    clockEdge();
    applyStimulus(OP_NONE, 12'h000, 64'd0, EV_IRQT | EV_IRQE | EV_TAKE, 64'h400);
    checkOutput("irq_pending", 64'(o_intr_pending), 64'd1);
    clockEdge();
    applyStimulus(OP_RS, 12'h342, 64'd0, 8'h00, 64'd0);
    checkOutput("irq_mcause", o_csr_rdata, 64'h8000_0000_0000_000b);
    checkOutput("irq_redir_pc", o_redirect_pc, 64'h12c);
    clockEdge();

    // ecall + mret + csrrw mscratch in one cycle: only the trap lands
    applyStimulus(OP_RW, 12'h340, 64'h1234, 8'h00, 64'd0);
    clockEdge();
    applyStimulus(OP_RW, 12'h340, 64'hdead, EV_ECALL | EV_MRET, 64'h2000);
    clockEdge();
    applyStimulus(OP_RS, 12'h340, 64'd0, 8'h00, 64'd0);
    checkOutput("collide_mscratch", o_csr_rdata, 64'h1234);
    checkOutput("collide_redir_pc", o_redirect_pc, 64'h100);
    clockEdge();

    // read-only and unimplemented addresses
    applyStimulus(OP_RS, 12'hF14, 64'd0, 8'h00, 64'd0);
    checkOutput("hartid_read", o_csr_rdata, HARTID);
    checkOutput("hartid_read_legal", 64'(o_csr_illegal), 64'd0);
    clockEdge();
    applyStimulus(OP_RW, 12'hF14, 64'h77, 8'h00, 64'd0);
    checkOutput("hartid_write_illegal", 64'(o_csr_illegal), 64'd1);
    checkOutput("hartid_write_rdata", o_csr_rdata, 64'd0);
    clockEdge();
    applyStimulus(OP_RW, 12'h7C0, 64'h77, 8'h00, 64'd0);
    checkOutput("unimpl_illegal", 64'(o_csr_illegal), 64'd1);
    clockEdge();

    // counter wrap and write-over-increment
    applyStimulus(OP_RW, 12'hB00, {64{1'b1}}, 8'h00, 64'd0);
    clockEdge();
    applyStimulus(OP_RS, 12'hB00, 64'd0, 8'h00, 64'd0);
    checkOutput("mcycle_ones", o_csr_rdata, {64{1'b1}});
    clockEdge();
    applyStimulus(OP_RS, 12'hB00, 64'd0, 8'h00, 64'd0);
    checkOutput("mcycle_wrap", o_csr_rdata, 64'd0);
    clockEdge();
    applyStimulus(OP_RW, 12'hB02, 64'h55, EV_RETIRE, 64'd0);
    clockEdge();
    applyStimulus(OP_RS, 12'hB02, 64'd0, 8'h00, 64'd0);
    checkOutput("minstret_write_wins", o_csr_rdata, 64'h55);
    clockEdge();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      wd = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) wd = 64'd0;
      ev = 8'h00;
      ev[0] = ($urandom_range(0, 15) == 0);
      ev[1] = ($urandom_range(0, 15) == 0);
      ev[2] = ($urandom_range(0, 11) == 0);
      ev[3] = 1'($urandom_range(0, 1));
      ev[4] = 1'($urandom_range(0, 1));
      ev[5] = 1'($urandom_range(0, 1));
      ev[6] = 1'($urandom_range(0, 1));
      ev[7] = ($urandom_range(0, 3) == 0);
      applyStimulus(2'($urandom_range(0, 3)), addrs[$urandom_range(0, 13)], wd, ev,
                    {$urandom, $urandom});
      clockEdge();
    end

    // reset asserted during a redirect cycle
    applyStimulus(OP_RW, 12'h300, 64'h88, 8'h00, 64'd0);
    clockEdge();
    applyStimulus(OP_NONE, 12'h000, 64'd0, EV_EBREAK, 64'h3000);
    clockEdge();
    applyStimulus(OP_RS, 12'h300, 64'd0, 8'h00, 64'd0);
    checkOutput("pre_rst_redir_valid", 64'(o_redirect_valid), 64'd1);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_cancel_redir", 64'(o_redirect_valid), 64'd0);
    checkOutput("rst_mstatus_mid", o_csr_rdata, MSTATUS_RST);
    clockEdge();
    #1 rst = 1'b0;
    applyStimulus(OP_RS, 12'hB00, 64'd0, 8'h00, 64'd0);
    checkOutput("mcycle_restart", o_csr_rdata, 64'd0);
    clockEdge();
    applyStimulus(OP_RS, 12'hB00, 64'd0, 8'h00, 64'd0);
    checkOutput("mcycle_restart_first", o_csr_rdata, 64'd1);
    clockEdge();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/csr_file_v2.md
CSR_FILE_V2 -- requirements
Module: csr_file_v2

Interface
REQ-001 The module SHALL have parameter XLEN, default 64, meaning CSR and PC width (32 or 64).
REQ-002 The module SHALL have parameter MSTATUS_RST, default 'ha00001800, meaning the mstatus reset value.
REQ-003 The module SHALL have parameter HARTID, default 0, meaning the read-only mhartid value.
REQ-004 The module SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- i_csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC.
- i_csr_addr  in  12  CSR address.
- i_csr_wdata  in  XLEN  write operand.
- o_csr_rdata  out  XLEN  pre-write CSR value (combinational).
- o_csr_illegal  out  1  access is illegal (combinational).
- i_instr_retire  in  1  one instruction retired this cycle.
- i_ecall, i_ebreak, i_mret  in  1 each  exception/return events.
- i_trap_pc  in  XLEN  PC to save in mepc.
- i_irq_timer, i_irq_soft, i_irq_ext  in  1 each  level interrupt lines.
- o_intr_pending  out  1  an enabled interrupt is takeable.
- i_intr_take  in  1  core takes the pending interrupt this cycle.
- o_redirect_valid  out  1  one-cycle redirect strobe.
- o_redirect_pc  out  XLEN  redirect target.

Function
REQ-005 The module SHALL implement these CSRs: mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344, mcycle B00, minstret B02, and read-only mhartid F14.
REQ-006 Write data SHALL be: RW = wdata; RS = old | wdata; RC = old & ~wdata.
REQ-007 A write attempt SHALL be defined as op RW, or op RS/RC with wdata != 0.
REQ-008 o_csr_illegal SHALL be 1 when op != 00 and either the address is unimplemented or a write attempt targets an address with [11:10] = 2'b11.
REQ-009 An illegal access SHALL change no state and SHALL drive o_csr_rdata to 0.
REQ-010 When op = 00, o_csr_rdata SHALL be 0.
REQ-011 mip bits 3 (MSIP), 7 (MTIP) and 11 (MEIP) SHALL be registered copies of i_irq_soft, i_irq_timer and i_irq_ext; mip writes SHALL be ignored.
REQ-012 mepc[1:0] SHALL read as 0 and SHALL not be writable.
REQ-013 mtvec[1:0] SHALL select the trap mode: 00 direct, 01 vectored; values 10 and 11 SHALL be treated as direct.
REQ-014 o_intr_pending SHALL equal mstatus.MIE & |(mip & mie & 'h888).
REQ-015 The interrupt cause SHALL be selected by priority MEI (11) > MSI (3) > MTI (7).
REQ-016 When i_intr_take = 1 while o_intr_pending = 0, the input SHALL be ignored.
REQ-017 Same-cycle events SHALL be resolved by priority intr_take > ebreak > ecall > mret > CSR write; only the highest-priority event SHALL take effect.
REQ-018 On a trap (interrupt, ebreak or ecall):
- mepc <= i_trap_pc with [1:0] cleared;
- mcause <= {1, cause} for an interrupt, 3 for ebreak, 11 for ecall;
- mtval <= 0;
- MPIE <= MIE, MIE <= 0, MPP <= 2'b11.
REQ-019 The trap target SHALL be mtvec base; in vectored mode an interrupt SHALL target base + 4 × cause.
REQ-020 On mret: MIE <= MPIE, MPIE <= 1, MPP <= 2'b11, and the target SHALL be the current mepc.
REQ-021 o_redirect_valid SHALL pulse for exactly one cycle, in the cycle after a trap or mret, with o_redirect_pc registered in the same cycle.
REQ-022 mcycle SHALL increment every cycle; minstret SHALL increment when i_instr_retire = 1.
REQ-023 Both counters SHALL wrap from all-ones to 0.
REQ-024 A CSR write to a counter SHALL override its increment in that cycle.
REQ-025 A CSR write SHALL become visible on o_csr_rdata in the next cycle.

Reset
REQ-026 While rst = 1, the module SHALL hold: mstatus = MSTATUS_RST; all other CSRs 0; o_redirect_valid 0; o_redirect_pc 0.
REQ-027 When rst asserts mid-operation, it SHALL immediately cancel any pending redirect.
REQ-028 After rst deasserts, mcycle SHALL start counting on the first clk edge.

Verification
REQ-029 The bench SHALL cover: csrrw mtvec 'h8000_0101 then ecall with pc 'h8000_0010 -> next cycle redirect to 'h8000_0100, mepc 'h8000_0010, mcause 'hb, MIE 0.
REQ-030 The bench SHALL cover: MIE = 1, mie = 'h880, timer and ext asserted, vectored mtvec base 'h100, intr_take -> mcause 'h8000_0000_0000_000b, redirect 'h12c.
REQ-031 The bench SHALL cover: same-cycle ecall, mret and csrrw mscratch -> trap only; mscratch unchanged.
REQ-032 The bench SHALL cover: RS 0 to mhartid -> legal, rdata HARTID; RW to mhartid -> illegal, rdata 0; RW to 'h7C0 -> illegal.
REQ-033 The bench SHALL cover: mcycle written all-ones -> next cycle 0; minstret write coinciding with retire -> written value held.
REQ-034 The bench SHALL cover: rst pulse during the redirect cycle -> o_redirect_valid 0 and mstatus = MSTATUS_RST.
